// File: rtl/mem_pkg.sv
// Shared types and helpers for the LEGv8 memory-access stage.
package mem_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, DONE, ERR} mem_state_t;
    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} xfer_size_t;

    localparam int DW_BYTES = 8;

    // Number of bytes moved by a transfer of the given size (1, 2, 4 or 8).
    function automatic logic [3:0] size_bytes(input xfer_size_t size);
        case (size)
            SZ_B:    return 4'd1;
            SZ_H:    return 4'd2;
            SZ_W:    return 4'd4;
            default: return 4'd8;
        endcase
    endfunction

endpackage

// File: rtl/byte_lane_align.sv
// Byte-lane steering for one doubleword bus beat: enables, store shift,
// load extraction and alignment check. Purely combinational.
module byte_lane_align
    import mem_pkg::*;
(
    input  xfer_size_t  size,
    input  logic [2:0]  lane,
    input  logic [63:0] write_data,
    input  logic [63:0] mem_rdata,
    output logic [7:0]  be,
    output logic [63:0] wdata_shifted,
    output logic [63:0] rdata_extracted,
    output logic        misalign
);

    logic [3:0]  nbytes;
    logic [15:0] be_wide;
    logic [63:0] rdata_lane;

    // NOTE: every output of a combinational block gets a value on every path,
    // otherwise synthesis infers a latch to hold the old one.
    always_comb begin
        nbytes        = size_bytes(size);
        be_wide       = ((16'd1 << nbytes) - 16'd1) << lane;
        be            = be_wide[7:0];
        wdata_shifted = write_data << {lane, 3'b000};
        rdata_lane    = mem_rdata >> {lane, 3'b000};

        case (size)
            SZ_B:    rdata_extracted = {56'd0, rdata_lane[7:0]};
            SZ_H:    rdata_extracted = {48'd0, rdata_lane[15:0]};
            SZ_W:    rdata_extracted = {32'd0, rdata_lane[31:0]};
            default: rdata_extracted = rdata_lane;
        endcase

        // Natural alignment, plus an explicit guard against spilling past the doubleword.
        misalign = ((lane & (nbytes[2:0] - 3'd1)) != 3'd0)
                || (({1'b0, lane} + nbytes) > 4'(DW_BYTES));
    end

endmodule

// File: rtl/data_mem_access.sv
// LEGv8 memory-access stage: runs one load/store over a req/ack bus,
// stalls the core meanwhile, and aborts accesses that never get acked.
module data_mem_access
    import mem_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [1:0]  xfer_size,
    input  logic [63:0] dm_address_in,
    input  logic [63:0] write_data,
    output logic        mem_req,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    output logic [7:0]  mem_be,
    input  logic        mem_ack,
    input  logic [63:0] mem_rdata,
    output logic        stall,
    output logic [63:0] dm_read_data,
    output logic [63:0] dm_address,
    output logic        wb_valid,
    output logic        mem_err
);

    mem_state_t       state, next_state;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       be;
    logic [63:0]      wdata_shifted, rdata_extracted;
    logic             misalign, op, illegal;
    logic             start, reject, complete, timed_out;

    assign op         = MemRead ^ MemWrite;
    assign illegal    = MemRead & MemWrite;
    assign dm_address = dm_address_in;

    // The core holds its inputs while stalled, so live inputs stay valid through WAIT.
    byte_lane_align u_align (
        .size            (xfer_size_t'(xfer_size)),
        .lane            (dm_address_in[2:0]),
        .write_data      (write_data),
        .mem_rdata       (mem_rdata),
        .be              (be),
        .wdata_shifted   (wdata_shifted),
        .rdata_extracted (rdata_extracted),
        .misalign        (misalign)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start)       next_state = WAIT;
                else if (reject) next_state = ERR;
            end
            WAIT: begin
                if (complete)       next_state = DONE;
                else if (timed_out) next_state = ERR;
            end
            default: next_state = IDLE;
        endcase
    end

    // An ack on the final WAIT cycle takes priority over the timeout.
    always_comb begin
        start     = (state == IDLE) && op && !misalign;
        reject    = (state == IDLE) && (illegal || (op && misalign));
        complete  = (state == WAIT) && mem_ack;
        timed_out = (state == WAIT) && !mem_ack && (cnt == CNT_W'(TIMEOUT - 1));
        stall     = start || (state == WAIT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            mem_be       <= '0;
            cnt          <= '0;
            dm_read_data <= '0;
            wb_valid     <= 1'b0;
            mem_err      <= 1'b0;
        end else begin
            wb_valid <= 1'b0;
            mem_err  <= 1'b0;
            if (start) begin
                mem_req   <= 1'b1;
                mem_we    <= MemWrite;
                mem_addr  <= {dm_address_in[63:3], 3'b000};
                mem_wdata <= wdata_shifted;
                mem_be    <= be;
                cnt       <= '0;
            end else if (reject) begin
                mem_err <= 1'b1;
            end else if (complete) begin
                mem_req  <= 1'b0;
                wb_valid <= 1'b1;
                if (!mem_we) dm_read_data <= rdata_extracted;
            end else if (timed_out) begin
                mem_req <= 1'b0;
                mem_err <= 1'b1;
            end else if (state == WAIT) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_data_mem_access.sv
// Scoreboard bench for data_mem_access: expectations queued at stimulus,
// popped when the stage reports wb_valid or mem_err.
module tb_data_mem_access;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemRead, MemWrite;
    logic [1:0]  xfer_size;
    logic [63:0] dm_address_in, write_data;
    logic        mem_req, mem_we;
    logic [63:0] mem_addr, mem_wdata;
    logic [7:0]  mem_be;
    logic        mem_ack;
    logic [63:0] mem_rdata;
    logic        stall;
    logic [63:0] dm_read_data, dm_address;
    logic        wb_valid, mem_err;

    data_mem_access dut (
        .clk           (clk),
        .reset         (reset),
        .MemRead       (MemRead),
        .MemWrite      (MemWrite),
        .xfer_size     (xfer_size),
        .dm_address_in (dm_address_in),
        .write_data    (write_data),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_be        (mem_be),
        .mem_ack       (mem_ack),
        .mem_rdata     (mem_rdata),
        .stall         (stall),
        .dm_read_data  (dm_read_data),
        .dm_address    (dm_address),
        .wb_valid      (wb_valid),
        .mem_err       (mem_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_err;
        logic [63:0] dm;
        logic [63:0] addr;
        logic [7:0]  be;
        logic        we;
        logic [63:0] wdata;
        int          req_cycles;
        int          latency;
        int          stall_cycles;
    } exp_t;

    exp_t        sb[$];
    int          checks   = 0;
    int          failures = 0;
    logic [63:0] model_dm = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // ack_wait: WAIT cycle (1-based) on which mem_ack is driven; 0 means never.
    task automatic run_access(input logic rd, input logic wr, input logic [1:0] sz,
                              input logic [63:0] addr, input logic [63:0] wd,
                              input logic [63:0] rdata, input int ack_wait);
        exp_t        e;
        int          nbytes, lane, cyc, wait_idx, stall_cnt, req_cnt;
        bit          bad, timeout, done;
        logic [63:0] mask;

        nbytes  = 1 << sz;
        lane    = int'(addr[2:0]);
        bad     = (rd && wr) || (lane % nbytes != 0) || (lane + nbytes > 8);
        timeout = !bad && (ack_wait == 0 || ack_wait > 64);
        mask    = (nbytes == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * nbytes)) - 64'd1);

        e.is_err = bad || timeout;
        e.addr   = {addr[63:3], 3'b000};
        e.be     = 8'(((1 << nbytes) - 1) << lane);
        e.we     = wr;
        e.wdata  = wd << (8 * lane);
        if (rd && !wr && !e.is_err) model_dm = (rdata >> (8 * lane)) & mask;
        e.dm           = model_dm;
        e.req_cycles   = bad ? 0 : (timeout ? 64 : ack_wait);
        e.latency      = bad ? 1 : e.req_cycles + 1;
        e.stall_cycles = bad ? 0 : e.req_cycles + 1;
        sb.push_back(e);

        @(negedge clk);
        MemRead = rd; MemWrite = wr; xfer_size = sz;
        dm_address_in = addr; write_data = wd; mem_rdata = rdata; mem_ack = 1'b0;
        #1;
        check("stall_idle", 64'(stall), 64'(!bad));
        check("dm_address", dm_address, addr);

        stall_cnt = stall ? 1 : 0;
        req_cnt = 0; wait_idx = 0; cyc = 0; done = 0;
        while (!done && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (stall) stall_cnt++;
            if (mem_req) begin
                req_cnt++;
                wait_idx++;
                if (wait_idx == 1) begin
                    check("bus_addr", mem_addr, e.addr);
                    check("bus_be", 64'(mem_be), 64'(e.be));
                    check("bus_we", 64'(mem_we), 64'(e.we));
                    if (wr) check("bus_wdata", mem_wdata, e.wdata);
                end
                mem_ack = (wait_idx == ack_wait);
            end else begin
                mem_ack = 1'b0;
            end
            if (wb_valid || mem_err) begin
                done = 1;
                e = sb.pop_front();
                check("mem_err", 64'(mem_err), 64'(e.is_err));
                check("wb_valid", 64'(wb_valid), 64'(!e.is_err));
                check("dm_read_data", dm_read_data, e.dm);
                check("req_cycles", 64'(req_cnt), 64'(e.req_cycles));
                check("latency", 64'(cyc), 64'(e.latency));
                check("stall_cycles", 64'(stall_cnt), 64'(e.stall_cycles));
                check("req_low_at_end", 64'(mem_req), 64'd0);
                MemRead = 1'b0; MemWrite = 1'b0; mem_ack = 1'b0;
            end
        end
        if (!done) begin
            check("response_bound", 64'd0, 64'd1);
            if (sb.size() > 0) void'(sb.pop_front());
            MemRead = 1'b0; MemWrite = 1'b0; mem_ack = 1'b0;
        end

        @(negedge clk);
        check("wb_pulse_low", 64'(wb_valid), 64'd0);
        check("err_pulse_low", 64'(mem_err), 64'd0);
        check("stall_after", 64'(stall), 64'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req"}, 64'(mem_req), 64'd0);
        check({tag, "_we"}, 64'(mem_we), 64'd0);
        check({tag, "_addr"}, mem_addr, 64'd0);
        check({tag, "_wdata"}, mem_wdata, 64'd0);
        check({tag, "_be"}, 64'(mem_be), 64'd0);
        check({tag, "_stall"}, 64'(stall), 64'd0);
        check({tag, "_dm"}, dm_read_data, 64'd0);
        check({tag, "_wb"}, 64'(wb_valid), 64'd0);
        check({tag, "_err"}, 64'(mem_err), 64'd0);
    endtask

    initial begin
        reset = 1'b1;
        MemRead = 1'b0; MemWrite = 1'b0; xfer_size = 2'b00;
        dm_address_in = '0; write_data = '0; mem_rdata = '0; mem_ack = 1'b0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;
        @(negedge clk);

        // Doubleword load, ack on third WAIT cycle.
        run_access(1'b1, 1'b0, 2'b11, 64'h1000, '0, 64'h1122334455667788, 3);
        // Byte load at lane 5, immediate ack.
        run_access(1'b1, 1'b0, 2'b00, 64'h1005, '0, 64'h1122334455667788, 1);
        // Halfword store at lane 2.
        run_access(1'b0, 1'b1, 2'b01, 64'h2002, 64'hABCD, 64'hDEAD_BEEF_DEAD_BEEF, 2);
        // Word load crossing the doubleword boundary, then an illegal op.
        run_access(1'b1, 1'b0, 2'b10, 64'h3006, '0, '0, 1);
        run_access(1'b1, 1'b1, 2'b11, 64'h3000, 64'h55, '0, 1);
        // Halfword load misaligned to an odd lane.
        run_access(1'b1, 1'b0, 2'b01, 64'h3003, '0, '0, 1);
        // No ack: times out after exactly 64 WAIT cycles.
        run_access(1'b1, 1'b0, 2'b11, 64'h4000, '0, 64'h0123456789ABCDEF, 0);
        // Ack on the 64th WAIT cycle wins over the timeout.
        run_access(1'b1, 1'b0, 2'b10, 64'h4004, '0, 64'hCAFEF00D_12345678, 64);
        // Halfword load at the top lane, store doubleword.
        run_access(1'b1, 1'b0, 2'b01, 64'h5006, '0, 64'hBEEF_0000_0000_0000, 2);
        run_access(1'b0, 1'b1, 2'b11, 64'h6008, 64'hFEDC_BA98_7654_3210, '0, 1);

        // Reset two cycles into WAIT drops everything immediately.
        @(negedge clk);
        MemRead = 1'b1; MemWrite = 1'b0; xfer_size = 2'b11;
        dm_address_in = 64'h7000; mem_rdata = 64'h1111; mem_ack = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_reset_req", 64'(mem_req), 64'd1);
        #2;
        reset = 1'b1; MemRead = 1'b0;
        #1;
        check_all_zero("midreset");
        model_dm = '0;
        @(negedge clk);
        reset = 1'b0;

        run_access(1'b1, 1'b0, 2'b10, 64'h8000, '0, 64'h0000_0000_A5A5_5A5A, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "simulation time limit");
    end

endmodule
